// File: rtl/core_pkg.sv
// Shared core types: load/store sizes, LSU FSM states and the execute-to-LSU request bundle.
package core_pkg;

  localparam int unsigned LsuAddrW = 32;

  typedef enum logic [1:0] {
    LsuByte = 2'd0,
    LsuHalf = 2'd1,
    LsuWord = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StDone
  } lsu_state_e;

  typedef struct packed {
    logic                we;
    lsu_size_e           size;
    logic                is_unsigned;
    logic [LsuAddrW-1:0] addr;
    logic [31:0]         wdata;
  } lsu_req_t;

endpackage

// File: rtl/core_lsu_if.sv
// Data-memory request/grant/response bus between the LSU (master) and data memory (slave).
interface core_lsu_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              data_mem_req;
  logic              data_mem_grnt;
  logic [ADDR_W-1:0] data_mem_addr;
  logic              data_mem_wen;
  logic              data_mem_ren;
  logic [3:0]        data_mem_be;
  logic [31:0]       data_mem_wdata;
  logic              data_mem_rvalid;
  logic [31:0]       data_mem_rdata;

  modport master (
    output data_mem_req, data_mem_addr, data_mem_wen, data_mem_ren, data_mem_be, data_mem_wdata,
    input  data_mem_grnt, data_mem_rvalid, data_mem_rdata
  );

  modport slave (
    input  data_mem_req, data_mem_addr, data_mem_wen, data_mem_ren, data_mem_be, data_mem_wdata,
    output data_mem_grnt, data_mem_rvalid, data_mem_rdata
  );
endinterface

// File: rtl/core_lsu_align.sv
// Combinational lane logic: byte enables, store-lane replication, alignment check and
// load extraction with sign/zero extension.
module core_lsu_align
  import core_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        is_unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        err_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata_i[{off_i, 3'b000} +: 8];
  assign half_v = rdata_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    be_o    = 4'h0;
    wdata_o = wdata_i;
    err_o   = 1'b0;
    rdata_o = rdata_i;
    unique case (size_i)
      LsuByte: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~is_unsigned_i & byte_v[7]}}, byte_v};
      end
      LsuHalf: begin
        be_o    = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
        err_o   = off_i[0];
        rdata_o = {{16{~is_unsigned_i & half_v[15]}}, half_v};
      end
      LsuWord: begin
        be_o  = 4'hF;
        err_o = |off_i;
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: accepts one op from execute, runs the data-memory req/grant/rvalid
// handshake with registered bus outputs, and returns extended load data.
module core_lsu
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_unsigned_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic              lsu_ready_o,
  output logic              lsu_busy_o,
  output logic              lsu_done_o,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_err_o,
  core_lsu_if.master        data_mem_io
);

  lsu_state_e        state_q, state_d;
  logic              req_q, req_d, wen_q, wen_d, ren_q, ren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]        size_q, size_d, off_q, off_d;
  logic              uns_q, uns_d, err_q, err_d;

  logic              in_idle;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_rdata;
  logic              al_err;

  assign in_idle = (state_q == StIdle);

  // Idle: check/encode the incoming op; afterwards: extract using the captured op.
  core_lsu_align u_align (
    .size_i        (in_idle ? lsu_size_i : size_q),
    .off_i         (in_idle ? lsu_addr_i[1:0] : off_q),
    .is_unsigned_i (uns_q),
    .wdata_i       (lsu_wdata_i),
    .rdata_i       (data_mem_io.data_mem_rdata),
    .be_o          (al_be),
    .wdata_o       (al_wdata),
    .err_o         (al_err),
    .rdata_o       (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    off_d   = off_q;
    uns_d   = uns_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (lsu_req_i) begin
          rdata_d = '0;
          if (al_err) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            req_d   = 1'b1;
            wen_d   = lsu_we_i;
            ren_d   = ~lsu_we_i;
            addr_d  = {lsu_addr_i[ADDR_W-1:2], 2'b00};
            be_d    = al_be;
            wdata_d = al_wdata;
            size_d  = lsu_size_i;
            off_d   = lsu_addr_i[1:0];
            uns_d   = lsu_unsigned_i;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (data_mem_io.data_mem_grnt) begin
          req_d   = 1'b0;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
          addr_d  = '0;
          be_d    = '0;
          wdata_d = '0;
          state_d = wen_q ? StDone : StResp;
        end
      end
      StResp: begin
        if (data_mem_io.data_mem_rvalid) begin
          rdata_d = al_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      off_q   <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
    end
  end

  assign lsu_ready_o = in_idle;
  assign lsu_busy_o  = ~in_idle;
  assign lsu_done_o  = (state_q == StDone) & ~err_q;
  assign lsu_err_o   = (state_q == StDone) & err_q;
  assign lsu_rdata_o = lsu_done_o ? rdata_q : 32'h0;

  assign data_mem_io.data_mem_req   = req_q;
  assign data_mem_io.data_mem_wen   = wen_q;
  assign data_mem_io.data_mem_ren   = ren_q;
  assign data_mem_io.data_mem_addr  = addr_q;
  assign data_mem_io.data_mem_be    = be_q;
  assign data_mem_io.data_mem_wdata = wdata_q;

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: directed vector table, reset/back-to-back sequences
// and randomized ops checked against an arithmetic reference model.
module tb_core_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, busy, done, err;
  logic [31:0] rdata;
  int          n_pass = 0, n_total = 0, done_cnt = 0;

  always #5 clk = ~clk;

  core_lsu_if #(.ADDR_W(32)) mem_if ();

  core_lsu #(.ADDR_W(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .lsu_req_i      (req),
    .lsu_we_i       (we),
    .lsu_size_i     (size),
    .lsu_unsigned_i (uns),
    .lsu_addr_i     (addr),
    .lsu_wdata_i    (wdata),
    .lsu_ready_o    (ready),
    .lsu_busy_o     (busy),
    .lsu_done_o     (done),
    .lsu_rdata_o    (rdata),
    .lsu_err_o      (err),
    .data_mem_io    (mem_if)
  );

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  always @(posedge clk) begin
    assert (!(mem_if.data_mem_grnt && mem_if.data_mem_rvalid))
      else $error("FAIL proto: grant and rvalid in the same cycle");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          gw;
    int          rv;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  // Reference: plain arithmetic over byte counts and masks.
  function automatic vec_t model(input logic w, input logic [1:0] sz, input logic u,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] m, input int gw, input int rv);
    vec_t v;
    longint nbytes, off, mask, val;
    v.we = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd; v.mem = m;
    v.gw = gw; v.rv = rv;
    off = longint'(a % 4);
    nbytes = (sz == 2'd3) ? 0 : (64'd1 << sz);
    v.exp_err = (nbytes == 0) || ((longint'(a) % nbytes) != 0);
    v.exp_be = '0; v.exp_wdata = '0; v.exp_rdata = '0;
    if (!v.exp_err) begin
      mask = (64'd1 << (8 * nbytes)) - 1;
      v.exp_be = 4'(((64'd1 << nbytes) - 1) << off);
      if (nbytes == 4) v.exp_wdata = wd;
      else v.exp_wdata = 32'((longint'(wd) & mask) * ((nbytes == 1) ? 64'h01010101 : 64'h00010001));
      if (!w) begin
        val = (longint'(m) >> (8 * off)) & mask;
        if (!u && val >= (mask + 1) / 2) val = val | ~mask;
        v.exp_rdata = 32'(val);
      end
    end
    return v;
  endfunction

  task automatic run_op(input vec_t v);
    int d0;
    logic [31:0] eaddr;
    eaddr = {v.addr[31:2], 2'b00};
    @(negedge clk);
    check("ready_before", ready, 1);
    req = 1; we = v.we; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata;
    d0 = done_cnt;
    @(negedge clk);
    req = 0;
    if (v.exp_err) begin
      check("err_pulse", {err, done, mem_if.data_mem_req}, 3'b100);
      @(negedge clk);
      check("err_ready", {ready, err}, 2'b10);
      check("err_done_cnt", done_cnt - d0, 0);
    end else begin
      check("memreq", {mem_if.data_mem_req, mem_if.data_mem_wen, mem_if.data_mem_ren},
            {1'b1, v.we, ~v.we});
      check("addr", mem_if.data_mem_addr, eaddr);
      check("be", mem_if.data_mem_be, v.exp_be);
      if (v.we) check("wdata", mem_if.data_mem_wdata, v.exp_wdata);
      for (int i = 0; i < v.gw; i++) begin
        @(negedge clk);
        check("hold", {mem_if.data_mem_req, done, mem_if.data_mem_be, mem_if.data_mem_addr[27:0]},
              {1'b1, 1'b0, v.exp_be, eaddr[27:0]});
        if (v.we) check("hold_wdata", mem_if.data_mem_wdata, v.exp_wdata);
      end
      mem_if.data_mem_grnt = 1;
      @(negedge clk);
      mem_if.data_mem_grnt = 0;
      check("req_drop", mem_if.data_mem_req, 0);
      if (v.we) begin
        check("st_done", {done, err, ready}, 3'b100);
        check("st_rdata", rdata, 0);
      end else begin
        check("ld_wait", {done, ready}, 2'b00);
        for (int i = 1; i < v.rv; i++) @(negedge clk);
        mem_if.data_mem_rvalid = 1; mem_if.data_mem_rdata = v.mem;
        @(negedge clk);
        mem_if.data_mem_rvalid = 0; mem_if.data_mem_rdata = $urandom;
        check("ld_done", {done, err}, 2'b10);
        check("ld_rdata", rdata, v.exp_rdata);
      end
      @(negedge clk);
      check("ready_after", {ready, done}, 2'b10);
      check("done_once", done_cnt - d0, 1);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    check(nm, {ready, busy, done, err, mem_if.data_mem_req, mem_if.data_mem_wen,
               mem_if.data_mem_ren, mem_if.data_mem_be}, {1'b1, 10'b0});
    check({nm, "_buses"}, mem_if.data_mem_addr | mem_if.data_mem_wdata | rdata, 0);
  endtask

  vec_t tbl[11];
  vec_t rv;
  int   d0;

  initial begin
    mem_if.data_mem_grnt = 0; mem_if.data_mem_rvalid = 0; mem_if.data_mem_rdata = '0;
    //          we  sz    u   addr       wdata         mem           gw rv err be      wlane         rres
    tbl[0]  = '{1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0,        2, 1, 0, 4'hF,   32'hDEADBEEF, 32'h0};
    tbl[1]  = '{0, 2'd0, 0, 32'h103, 32'h0,        32'h80FF1234, 0, 3, 0, 4'b1000, 32'h0,       32'hFFFFFF80};
    tbl[2]  = '{0, 2'd0, 1, 32'h103, 32'h0,        32'h80FF1234, 0, 3, 0, 4'b1000, 32'h0,       32'h00000080};
    tbl[3]  = '{0, 2'd1, 0, 32'h102, 32'h0,        32'h80010000, 1, 1, 0, 4'b1100, 32'h0,       32'hFFFF8001};
    tbl[4]  = '{1, 2'd1, 0, 32'h102, 32'h0000ABCD, 32'h0,        0, 1, 0, 4'b1100, 32'hABCDABCD, 32'h0};
    tbl[5]  = '{0, 2'd2, 0, 32'h102, 32'h0,        32'h0,        0, 1, 1, 4'h0,   32'h0,        32'h0};
    tbl[6]  = '{0, 2'd3, 0, 32'h100, 32'h0,        32'h0,        0, 1, 1, 4'h0,   32'h0,        32'h0};
    tbl[7]  = '{1, 2'd0, 0, 32'h101, 32'h12345678, 32'h0,        1, 1, 0, 4'b0010, 32'h78787878, 32'h0};
    tbl[8]  = '{0, 2'd1, 1, 32'h100, 32'h0,        32'h1234F00D, 0, 2, 0, 4'b0011, 32'h0,       32'h0000F00D};
    tbl[9]  = '{0, 2'd2, 0, 32'h104, 32'h0,        32'hCAFEF00D, 0, 1, 0, 4'hF,   32'h0,        32'hCAFEF00D};
    tbl[10] = '{1, 2'd1, 0, 32'h101, 32'h5555,     32'h0,        0, 1, 1, 4'h0,   32'h0,        32'h0};

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 0;

    foreach (tbl[i]) run_op(tbl[i]);

    // Reset while waiting for load data; the late rvalid must be dropped.
    @(negedge clk);
    d0 = done_cnt;
    req = 1; we = 0; size = 2'd2; addr = 32'h300;
    @(negedge clk);
    req = 0; mem_if.data_mem_grnt = 1;
    @(negedge clk);
    mem_if.data_mem_grnt = 0; rst = 1;
    @(negedge clk);
    rst = 0; mem_if.data_mem_rvalid = 1; mem_if.data_mem_rdata = 32'h12345678;
    check_reset_vals("rst_mid");
    @(negedge clk);
    mem_if.data_mem_rvalid = 0;
    check_reset_vals("rst_stale_rvalid");
    check("rst_no_done", done_cnt - d0, 0);
    run_op(tbl[3]);

    // Spurious rvalid while idle.
    @(negedge clk);
    mem_if.data_mem_rvalid = 1; mem_if.data_mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_if.data_mem_rvalid = 0;
    check_reset_vals("idle_rvalid");

    // Request held high across busy: exactly one accept per idle cycle.
    d0 = done_cnt;
    req = 1; we = 1; size = 2'd2; addr = 32'h200; wdata = 32'h11111111;
    @(negedge clk);
    addr = 32'h204; wdata = 32'h22222222;
    @(negedge clk);
    check("b2b_hold_addr", mem_if.data_mem_addr, 32'h200);
    check("b2b_hold_wdata", mem_if.data_mem_wdata, 32'h11111111);
    mem_if.data_mem_grnt = 1;
    @(negedge clk);
    mem_if.data_mem_grnt = 0;
    check("b2b_done1", {done, ready, mem_if.data_mem_req}, 3'b100);
    @(negedge clk);
    check("b2b_idle", {ready, mem_if.data_mem_req}, 2'b10);
    @(negedge clk);
    req = 0;
    check("b2b_addr2", mem_if.data_mem_addr, 32'h204);
    check("b2b_wdata2", mem_if.data_mem_wdata, 32'h22222222);
    mem_if.data_mem_grnt = 1;
    @(negedge clk);
    mem_if.data_mem_grnt = 0;
    check("b2b_done2", done, 1);
    @(negedge clk);
    check("b2b_count", done_cnt - d0, 2);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rv = model($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1,
                 32'h1000 + 32'($urandom_range(0, 63)), $urandom, $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
      run_op(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_lsu.md
# core_lsu

Load/store unit for the core's memory stage. It takes one load or store per request from execute: the address comes from the execution adder and the store data from rs2. It drives the data-memory request/grant/response handshake and returns a sign- or zero-extended load result for regfile write-back. It sits directly downstream of `core_execution` and owns the core's `data_mem_*` ports.

## Interface
- ADDR_W, 32, address width; data path fixed at 32 bits
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- lsu_req_i  in  1  execute presents a memory op this cycle
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_size_i  in  2  LSU_BYTE=0, LSU_HALF=1, LSU_WORD=2, 3 = illegal
- lsu_unsigned_i  in  1  zero-extend load (LBU/LHU)
- lsu_addr_i  in  ADDR_W  byte address
- lsu_wdata_i  in  32  store data, LSB-aligned
- lsu_ready_o  out  1  high only in IDLE; request accepted when lsu_req_i && lsu_ready_o
- lsu_busy_o  out  1  !lsu_ready_o; stall for fetch/decode
- lsu_done_o  out  1  one-cycle completion pulse, loads and stores
- lsu_rdata_o  out  32  extended load data; valid with lsu_done_o on loads, 0 otherwise
- lsu_err_o  out  1  one-cycle pulse: misaligned access or illegal size
- data_mem_req_o  out  1  memory request
- data_mem_grnt_i  in  1  memory accepts request this cycle
- data_mem_addr_o  out  ADDR_W  word-aligned address, [1:0]=0
- data_mem_wen_o / data_mem_ren_o  out  1 each  store / load qualifier
- data_mem_be_o  out  4  byte enables
- data_mem_wdata_o  out  32  lane-replicated store data
- data_mem_rvalid_i  in  1  load data valid
- data_mem_rdata_i  in  32  load data word

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, on accept with an aligned, legal op: register addr, size, unsigned, we, wdata and byte offset; go to REQ.
- IDLE, on accept with a misaligned or illegal op: go to DONE with the error flag set. No memory request is issued.
- Alignment rules: half needs addr[0]=0; word needs addr[1:0]=0; size 3 is always illegal.
- REQ: hold data_mem_req_o=1 and all `data_mem_*` outputs stable until grant.
- REQ, on grant: a store goes to DONE; a load goes to RESP.
- RESP: wait for data_mem_rvalid_i. On rvalid, capture the extracted and extended data, then go to DONE.
- DONE: pulse lsu_done_o, or lsu_err_o if the error flag is set, then return to IDLE.
- Byte enables: byte → 1<<off; half → 4'b0011<<off; word → 4'hF.
- Store data lanes: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Load extraction: byte = rdata[8*off+:8]; half = rdata[16*off[1]+:16]. Sign-extend unless lsu_unsigned_i was set at accept.
- data_mem_rvalid_i outside RESP is ignored; this covers stale responses after reset.
- lsu_req_i while busy is ignored. Execute holds the op until ready.

## Timing
- Reset values: state IDLE, lsu_ready_o=1, every other output 0, including data_mem_addr_o, data_mem_wdata_o and data_mem_be_o.
- All `data_mem_*` outputs are registered.
- Accept in cycle N → data_mem_req_o high in N+1.
- Grant seen in cycle M:
  - req drops in M+1.
  - Store: lsu_done_o in M+1, lsu_ready_o in M+2.
- rvalid seen in cycle K: lsu_done_o and lsu_rdata_o in K+1, lsu_ready_o in K+2.
- Minimum store latency: accept to done = 2 cycles. Minimum load latency (grant in N+1, rvalid in N+2): 3 cycles.
- Error path: accept in N → lsu_err_o in N+1, ready in N+2; lsu_done_o stays low.
- Grant and rvalid asserted in the same cycle are illegal for this memory protocol: rvalid is at least one cycle after grant. The bench asserts this.
- Reset mid-operation: in the cycle after the rst_i edge, state is IDLE and data_mem_req_o=0. A pending grant or rvalid is dropped.
- No wait limit: REQ and RESP stall indefinitely.

## Structure
- core_pkg gets:
  - `lsu_size_e` (BYTE/HALF/WORD)
  - `lsu_state_e` (IDLE/REQ/RESP/DONE)
  - a `lsu_req_t` struct {we, size, unsigned, addr, wdata}, also used by `core_ctrl_t`
- One combinational sub-module, `core_lsu_align`: BE/wdata generation, misalignment check, and load extraction/extension. It is reused by a future store buffer.

## Test plan
- Word store 0xDEADBEEF @0x100, grant after 2 wait cycles → be=F, addr=0x100, wdata=0xDEADBEEF held stable through the wait; lsu_done_o exactly once.
- LB @0x103, memory word 0x80FF_1234, rvalid 3 cycles after grant → lsu_rdata_o=0xFFFFFF80. The same access as LBU → 0x00000080.
- LH @0x102, word 0x8001_0000 → 0xFFFF8001. SH @0x102, wdata 0x0000ABCD → be=4'b1100, wdata=0xABCDABCD.
- LW @0x102 and size=3 → lsu_err_o pulses, data_mem_req_o never asserts, lsu_ready_o back two cycles after accept.
- Reset asserted in RESP, with rvalid arriving after reset → no lsu_done_o, all outputs at reset values. The next request completes normally.
- Back-to-back: lsu_req_i held high with a second op during busy → exactly one accept per IDLE. Spurious rvalid in IDLE → no effect.
